param_inter_switch: RTL and testbench

- Parametrised N-input / M-output packet switch for the data-route fabric.
- Next generation of the 5-in/8-out inter switch; the route is locked per packet (tlast-delimited) instead of following free-running ctrl.
- Supports multicast to any output subset through a forked handshake with per-output pending flags.
- One registered output stage (1-cycle latency, full throughput); width converters sit downstream on individual outputs.

---
 rtl/param_inter_switch_if.sv | 42 ++++
 rtl/param_inter_switch.sv | 144 ++++++++++++++
 tb/tb_param_inter_switch.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_inter_switch_if.sv
// Handshake bundle for param_inter_switch: route config, N AXIS inputs, M forked outputs.
// The switch uses the slave view; whoever drives the switch uses the master view.
interface param_inter_switch_if #(
   parameter int NUM_IN  = 5,
   parameter int NUM_OUT = 8,
   parameter int DWIDTH  = 1536,
   parameter int SEL_W   = 3
);
   logic [SEL_W-1:0]         cfg_in_sel;
   logic [NUM_OUT-1:0]       cfg_out_mask;
   logic                     cfg_valid;
   logic                     cfg_ready;
   logic                     cfg_err;

   logic [NUM_IN*DWIDTH-1:0] s_tdata;
   logic [NUM_IN-1:0]        s_tvalid;
   logic [NUM_IN-1:0]        s_tlast;
   logic [NUM_IN-1:0]        s_tready;

   logic [DWIDTH-1:0]        m_tdata;
   logic                     m_tlast;
   logic [NUM_OUT-1:0]       m_tvalid;
   logic [NUM_OUT-1:0]       m_tready;

   modport master (
      output cfg_in_sel, cfg_out_mask, cfg_valid,
      input  cfg_ready, cfg_err,
      output s_tdata, s_tvalid, s_tlast,
      input  s_tready,
      input  m_tdata, m_tlast, m_tvalid,
      output m_tready
   );

   modport slave (
      input  cfg_in_sel, cfg_out_mask, cfg_valid,
      output cfg_ready, cfg_err,
      input  s_tdata, s_tvalid, s_tlast,
      output s_tready,
      output m_tdata, m_tlast, m_tvalid,
      input  m_tready
   );
endinterface

// File: rtl/param_inter_switch.sv
// N-in / M-out packet switch: route locked per tlast-delimited packet, multicast via forked handshake.
// Optional beat counter port enabled by defining PARAM_INTER_SWITCH_BEAT_CNT_EN.
module param_inter_switch #(
   parameter int NUM_IN  = 5,
   parameter int NUM_OUT = 8,
   parameter int DWIDTH  = 1536,
   parameter int SEL_W   = 3
) (
   input  logic                clk,
   input  logic                rst,
   param_inter_switch_if.slave bus,
   output logic                busy
`ifdef PARAM_INTER_SWITCH_BEAT_CNT_EN
   ,
   output logic [15:0]         beat_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, ROUTE, FLUSH} state_e;

   state_e             state_q, state_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [NUM_OUT-1:0] mask_q, mask_d;
   logic [NUM_OUT-1:0] pending_q, pending_d;
   logic [DWIDTH-1:0]  data_q, data_d;
   logic               last_q, last_d;
   logic               err_q, err_d;

   logic               out_free;
   logic               cfg_legal;
   logic               accept;
   logic [DWIDTH-1:0]  in_data;
   logic               in_valid;
   logic               in_last;
   logic [NUM_IN-1:0]  s_ready;

   // The output register frees when every still-pending output handshakes this cycle.
   assign out_free  = (pending_q & ~bus.m_tready) == '0;
   assign cfg_legal = (bus.cfg_out_mask != '0) && (int'(bus.cfg_in_sel) < NUM_IN);

   always_comb begin
      in_data  = '0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      s_ready  = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (sel_q == SEL_W'(i)) begin
            in_data    = bus.s_tdata[i*DWIDTH +: DWIDTH];
            in_valid   = bus.s_tvalid[i];
            in_last    = bus.s_tlast[i];
            s_ready[i] = (state_q == ROUTE) && out_free;
         end
      end
   end

   assign accept = (state_q == ROUTE) && out_free && in_valid;

   always_comb begin
      // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
      state_d   = state_q;
      sel_d     = sel_q;
      mask_d    = mask_q;
      pending_d = pending_q & ~bus.m_tready;
      data_d    = data_q;
      last_d    = last_q;
      err_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.cfg_valid) begin
               if (cfg_legal) begin
                  sel_d   = bus.cfg_in_sel;
                  mask_d  = bus.cfg_out_mask;
                  state_d = ROUTE;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ROUTE: begin
            // A new beat overrides the drain result: its mask becomes the pending set.
            if (accept) begin
               data_d    = in_data;
               last_d    = in_last;
               pending_d = mask_q;
               if (in_last) state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (out_free) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses <= only, so every reader sees pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         sel_q     <= '0;
         mask_q    <= '0;
         pending_q <= '0;
         data_q    <= '0;
         last_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         mask_q    <= mask_d;
         pending_q <= pending_d;
         data_q    <= data_d;
         last_q    <= last_d;
         err_q     <= err_d;
      end
   end

`ifdef PARAM_INTER_SWITCH_BEAT_CNT_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if ((state_q == IDLE) && bus.cfg_valid && cfg_legal) begin
         cnt_d = '0;
      end else if (accept && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign beat_cnt = cnt_q;
`endif

   assign bus.cfg_ready = (state_q == IDLE) && !rst;
   assign bus.cfg_err   = err_q;
   assign bus.s_tready  = s_ready;
   assign bus.m_tdata   = data_q;
   assign bus.m_tlast   = last_q;
   assign bus.m_tvalid  = pending_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_param_inter_switch.sv
// Self-checking bench for param_inter_switch: cfg vector table, scoreboard on every output
// handshake, and hand-written sequences for unicast, multicast skew, route lock and reset.
module tb_param_inter_switch;
   localparam int NUM_IN  = 5;
   localparam int NUM_OUT = 8;
   localparam int DWIDTH  = 1536;
   localparam int SEL_W   = 3;

   typedef struct {
      logic [DWIDTH-1:0]  data;
      logic               last;
      logic [NUM_OUT-1:0] rem;
   } beat_t;

   typedef struct {
      logic [SEL_W-1:0]   sel;
      logic [NUM_OUT-1:0] mask;
      logic               exp_err;
   } cfg_vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;
`ifdef PARAM_INTER_SWITCH_BEAT_CNT_EN
   logic [15:0] beat_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   logic [SEL_W-1:0]   exp_sel  = '0;
   logic [NUM_OUT-1:0] exp_mask = '0;
   beat_t              sb_q[$];

   param_inter_switch_if #(
      .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .DWIDTH(DWIDTH), .SEL_W(SEL_W)
   ) bus ();

   param_inter_switch #(
      .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .DWIDTH(DWIDTH), .SEL_W(SEL_W)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
`ifdef PARAM_INTER_SWITCH_BEAT_CNT_EN
      ,
      .beat_cnt (beat_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_wide(input string name, input logic [DWIDTH-1:0] act,
                             input logic [DWIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got ..%h expected ..%h", name, act[63:0], exp[63:0]);
      end
   endtask

   function automatic logic [DWIDTH-1:0] pat(input int tag);
      logic [DWIDTH-1:0] v;
      for (int w = 0; w < DWIDTH/32; w++) v[w*32 +: 32] = (32'(tag) * 32'h9E3779B1) ^ 32'(w);
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: beats are queued as inputs are accepted and retired per output as outputs handshake.
   always @(posedge clk) begin : monitor
      beat_t b;
      if (rst) begin
         sb_q.delete();
      end else begin
         check("out_mask_only", 64'(bus.m_tvalid & ~exp_mask), 64'd0);
         check("unsel_ready", 64'(bus.s_tready & ~(NUM_IN'(1) << exp_sel)), 64'd0);
         for (int j = 0; j < NUM_OUT; j++) begin
            if (bus.m_tvalid[j] && bus.m_tready[j]) begin
               checks++;
               if (sb_q.size() == 0 || !sb_q[0].rem[j]) begin
                  failures++;
                  $display("FAIL sb_unexpected: beat on output %0d, queue depth %0d", j, sb_q.size());
               end else begin
                  b = sb_q[0];
                  check_wide("sb_data", bus.m_tdata, b.data);
                  check("sb_last", 64'(bus.m_tlast), 64'(b.last));
                  b.rem[j] = 1'b0;
                  if (b.rem == '0) void'(sb_q.pop_front());
                  else sb_q[0] = b;
               end
            end
         end
         for (int i = 0; i < NUM_IN; i++) begin
            if (bus.s_tvalid[i] && bus.s_tready[i]) begin
               b.data = bus.s_tdata[i*DWIDTH +: DWIDTH];
               b.last = bus.s_tlast[i];
               b.rem  = exp_mask;
               sb_q.push_back(b);
            end
         end
      end
   end

   task automatic do_cfg(input logic [SEL_W-1:0] sel, input logic [NUM_OUT-1:0] mask);
      bus.cfg_in_sel   = sel;
      bus.cfg_out_mask = mask;
      bus.cfg_valid    = 1'b1;
      #1;
      check("cfg_ready_idle", 64'(bus.cfg_ready), 64'd1);
      step();
      bus.cfg_valid = 1'b0;
      exp_sel  = sel;
      exp_mask = mask;
   endtask

   task automatic send_pkt(input int sel, input int n, input int tag);
      for (int b = 0; b < n; b++) begin
         bus.s_tvalid[sel] = 1'b1;
         bus.s_tdata[sel*DWIDTH +: DWIDTH] = pat(tag + b);
         bus.s_tlast[sel] = (b == n - 1);
         #1;
         for (int g = 0; g < 50 && !bus.s_tready[sel]; g++) step();
         check("send_ready", 64'(bus.s_tready[sel]), 64'd1);
         step();
      end
      bus.s_tvalid[sel] = 1'b0;
      bus.s_tlast[sel]  = 1'b0;
   endtask

   task automatic wait_idle();
      for (int g = 0; g < 50 && busy; g++) step();
      check("idle_wait", 64'(busy), 64'd0);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      cfg_vec_t tbl[7];
      tbl[0] = '{sel: 3'd2, mask: 8'h01, exp_err: 1'b0};
      tbl[1] = '{sel: 3'd6, mask: 8'h01, exp_err: 1'b1};
      tbl[2] = '{sel: 3'd0, mask: 8'h00, exp_err: 1'b1};
      tbl[3] = '{sel: 3'd5, mask: 8'hFF, exp_err: 1'b1};
      tbl[4] = '{sel: 3'd4, mask: 8'h80, exp_err: 1'b0};
      tbl[5] = '{sel: 3'd7, mask: 8'h0F, exp_err: 1'b1};
      tbl[6] = '{sel: 3'd0, mask: 8'hFF, exp_err: 1'b0};

      bus.cfg_in_sel   = '0;
      bus.cfg_out_mask = '0;
      bus.cfg_valid    = 1'b0;
      bus.s_tdata      = '0;
      bus.s_tvalid     = '0;
      bus.s_tlast      = '0;
      bus.m_tready     = '0;

      // Reset state
      step();
      check("rst_cfg_ready", 64'(bus.cfg_ready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_m_tvalid", 64'(bus.m_tvalid), 64'd0);
      check("rst_cfg_err", 64'(bus.cfg_err), 64'd0);
      check("rst_m_tlast", 64'(bus.m_tlast), 64'd0);
      check_wide("rst_m_tdata", bus.m_tdata, '0);
      step();
      rst = 1'b0;
      #1;
      check("post_rst_cfg_ready", 64'(bus.cfg_ready), 64'd1);
      check("post_rst_s_tready", 64'(bus.s_tready), 64'd0);

      // Cfg table: legal routes carry one single-beat packet, illegal ones must pulse cfg_err
      bus.m_tready = '1;
      for (int k = 0; k < 7; k++) begin
         bus.s_tvalid     = '1;
         bus.cfg_in_sel   = tbl[k].sel;
         bus.cfg_out_mask = tbl[k].mask;
         bus.cfg_valid    = 1'b1;
         #1;
         check("tbl_cfg_ready", 64'(bus.cfg_ready), 64'd1);
         check("tbl_s_tready_idle", 64'(bus.s_tready), 64'd0);
         step();
         bus.cfg_valid = 1'b0;
         bus.s_tvalid  = '0;
         check("tbl_cfg_err", 64'(bus.cfg_err), 64'(tbl[k].exp_err));
         check("tbl_busy", 64'(busy), 64'(!tbl[k].exp_err));
         if (!tbl[k].exp_err) begin
            exp_sel  = tbl[k].sel;
            exp_mask = tbl[k].mask;
            send_pkt(int'(tbl[k].sel), 1, 100 + k);
            wait_idle();
         end else begin
            step();
            check("tbl_err_pulse", 64'(bus.cfg_err), 64'd0);
            check("tbl_no_valid", 64'(bus.m_tvalid), 64'd0);
            check("tbl_stay_idle", 64'(busy), 64'd0);
         end
      end

      // Unicast: input 2 -> output 0, 4 beats, other inputs valid but must be ignored
      bus.m_tready = '1;
      do_cfg(3'd2, 8'h01);
      check("uni_pre_valid", 64'(bus.m_tvalid), 64'd0);
      bus.s_tvalid = '1;
      for (int i = 0; i < NUM_IN; i++) if (i != 2) bus.s_tdata[i*DWIDTH +: DWIDTH] = pat(900 + i);
      for (int b = 0; b < 4; b++) begin
         bus.s_tdata[2*DWIDTH +: DWIDTH] = pat(200 + b);
         bus.s_tlast[2] = (b == 3);
         #1;
         check("uni_s_tready", 64'(bus.s_tready), 64'h04);
         step();
         check("uni_m_tvalid", 64'(bus.m_tvalid), 64'h01);
         check("uni_m_tlast", 64'(bus.m_tlast), 64'(b == 3));
         check_wide("uni_m_tdata", bus.m_tdata, pat(200 + b));
      end
      bus.s_tvalid = '0;
      bus.s_tlast  = '0;
      check("uni_busy_flush", 64'(busy), 64'd1);
      step();
      check("uni_busy_idle", 64'(busy), 64'd0);

      // Multicast skew: mask 05, output 2 stalls for 3 cycles
      do_cfg(3'd1, 8'h05);
      bus.m_tready = 8'h01;
      bus.s_tvalid[1] = 1'b1;
      bus.s_tdata[1*DWIDTH +: DWIDTH] = pat(300);
      bus.s_tlast[1] = 1'b0;
      #1;
      check("mc_first_ready", 64'(bus.s_tready), 64'h02);
      step();
      bus.s_tdata[1*DWIDTH +: DWIDTH] = pat(301);
      bus.s_tlast[1] = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         if (c == 4) bus.m_tready = '1;
         #1;
         check("mc_m_tvalid", 64'(bus.m_tvalid), (c == 1) ? 64'h05 : 64'h04);
         check_wide("mc_hold_data", bus.m_tdata, pat(300));
         check("mc_s_tready", 64'(bus.s_tready), (c == 4) ? 64'h02 : 64'h00);
         step();
      end
      bus.s_tvalid[1] = 1'b0;
      bus.s_tlast[1]  = 1'b0;
      check("mc_second_valid", 64'(bus.m_tvalid), 64'h05);
      check("mc_second_last", 64'(bus.m_tlast), 64'd1);
      check_wide("mc_second_data", bus.m_tdata, pat(301));
      step();
      check("mc_idle", 64'(busy), 64'd0);
      check("mc_drained", 64'(bus.m_tvalid), 64'd0);

      // Route lock: a new request during ROUTE waits for IDLE; data only from the latched input
      do_cfg(3'd3, 8'h02);
      bus.cfg_in_sel   = 3'd0;
      bus.cfg_out_mask = 8'hFF;
      bus.cfg_valid    = 1'b1;
      bus.s_tvalid[0]  = 1'b1;
      bus.s_tdata[0*DWIDTH +: DWIDTH] = pat(999);
      bus.s_tlast[0]   = 1'b1;
      for (int b = 0; b < 3; b++) begin
         bus.s_tvalid[3] = 1'b1;
         bus.s_tdata[3*DWIDTH +: DWIDTH] = pat(400 + b);
         bus.s_tlast[3] = (b == 2);
         #1;
         check("lock_cfg_ready", 64'(bus.cfg_ready), 64'd0);
         check("lock_s_tready", 64'(bus.s_tready), 64'h08);
         step();
         check("lock_m_tvalid", 64'(bus.m_tvalid), 64'h02);
      end
      bus.s_tvalid[3] = 1'b0;
      bus.s_tlast[3]  = 1'b0;
      check("lock_flush_cfg_ready", 64'(bus.cfg_ready), 64'd0);
      step();
      check("lock_idle_busy", 64'(busy), 64'd0);
      check("lock_idle_cfg_ready", 64'(bus.cfg_ready), 64'd1);
      step();
      exp_sel  = 3'd0;
      exp_mask = 8'hFF;
      bus.cfg_valid = 1'b0;
      check("lock_new_route", 64'(busy), 64'd1);
      check("lock_new_no_valid", 64'(bus.m_tvalid), 64'd0);
      #1;
      check("lock_new_s_tready", 64'(bus.s_tready), 64'h01);
      step();
      bus.s_tvalid[0] = 1'b0;
      bus.s_tlast[0]  = 1'b0;
      check("lock_new_m_tvalid", 64'(bus.m_tvalid), 64'hFF);
      check_wide("lock_new_data", bus.m_tdata, pat(999));
      wait_idle();

      // Reset mid-packet: pending 03 must vanish immediately
      bus.m_tready = '0;
      do_cfg(3'd4, 8'h03);
      bus.s_tvalid[4] = 1'b1;
      bus.s_tdata[4*DWIDTH +: DWIDTH] = pat(500);
      bus.s_tlast[4] = 1'b0;
      step();
      bus.s_tvalid[4] = 1'b0;
      check("rmp_pending", 64'(bus.m_tvalid), 64'h03);
      check_wide("rmp_data", bus.m_tdata, pat(500));
      #2;
      rst = 1'b1;
      #1;
      check("rmp_async_valid", 64'(bus.m_tvalid), 64'd0);
      check_wide("rmp_async_data", bus.m_tdata, '0);
      check("rmp_cfg_ready_rst", 64'(bus.cfg_ready), 64'd0);
      check("rmp_busy_rst", 64'(busy), 64'd0);
      step();
      rst = 1'b0;
      bus.m_tready = '1;
      #1;
      check("rmp_busy_after", 64'(busy), 64'd0);
      check("rmp_cfg_ready_after", 64'(bus.cfg_ready), 64'd1);
      check("rmp_valid_after", 64'(bus.m_tvalid), 64'd0);

`ifdef PARAM_INTER_SWITCH_BEAT_CNT_EN
      // Beat counter: 300-beat packet, held after FLUSH, cleared by the next cfg accept
      check("cnt_reset", 64'(beat_cnt), 64'd0);
      do_cfg(3'd0, 8'h01);
      check("cnt_cleared", 64'(beat_cnt), 64'd0);
      send_pkt(0, 300, 2000);
      check("cnt_300", 64'(beat_cnt), 64'd300);
      wait_idle();
      step();
      step();
      check("cnt_held", 64'(beat_cnt), 64'd300);
      do_cfg(3'd2, 8'h01);
      check("cnt_clear_next", 64'(beat_cnt), 64'd0);
      send_pkt(2, 1, 3000);
      wait_idle();
      check("cnt_one", 64'(beat_cnt), 64'd1);
`endif

      step();
      step();
      check("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
